// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - snapshots systolic-array accumulators, saturates them and
// writes them row-major into the RAM result region through the req/grant arbiter.
module systolic_result_drain #(
    parameter int ROW        = 4,
    parameter int COL        = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 16,
    parameter int ADD_WIDTH  = 6,
    parameter int OUT_BASE   = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ROW*COL*ACC_WIDTH-1:0]   acc_data,
    input  logic                           grant_out,
    output logic                           req_out,
    output logic                           we,
    output logic [ADD_WIDTH:0]             addr,
    output logic [DATA_WIDTH-1:0]          wdata,
    output logic                           busy,
    output logic                           drained
);

    localparam int NW = ROW * COL;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADD_WIDTH:0]             BASE    = (ADD_WIDTH+1)'(OUT_BASE);
    localparam logic signed [ACC_WIDTH-1:0]    SAT_MAX = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0]    SAT_MIN = ACC_WIDTH'(-(64'sd1 <<< (DATA_WIDTH-1)));
    localparam logic [DATA_WIDTH-1:0]          DMAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]          DMIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IW-1:0]                  LAST    = IW'(NW - 1);

    logic [1:0]                  state;
    logic [IW-1:0]               idx;
    logic signed [ACC_WIDTH-1:0] snap [NW];

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX)
            return DMAX;
        else if (v < SAT_MIN)
            return DMIN;
        else
            return v[DATA_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            for (int i = 0; i < NW; i++)
                snap[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NW; i++)
                            snap[i] <= acc_data[i*ACC_WIDTH +: ACC_WIDTH];
                        idx   <= '0;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (grant_out)
                        state <= WRITE;
                end
                WRITE: begin
                    // idx parks on the last word so the read path never leaves the snapshot
                    if (grant_out) begin
                        if (idx == LAST)
                            state <= DONE;
                        else
                            idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_out = (state == REQ) || (state == WRITE);
        busy    = req_out;
        we      = (state == WRITE) && grant_out;
        drained = (state == DONE);
        if (state == IDLE) begin
            addr  = BASE;
            wdata = '0;
        end else begin
            addr  = BASE + (ADD_WIDTH+1)'(idx);
            wdata = sat(snap[idx]);
        end
    end

endmodule
